// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 Hz timing constants and counter types.
// Used by the sync counter and by any block that decodes scan position.
package vga_pkg;

  // Horizontal timing in pixel clocks.
  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;  // 800

  // Vertical timing in lines.
  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;
  localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;  // 525

  // Inclusive sync windows.
  localparam int H_SYNC_FIRST = H_VIS + H_FP;              // 656
  localparam int H_SYNC_LAST  = H_SYNC_FIRST + H_SYNC - 1; // 751
  localparam int V_SYNC_FIRST = V_VIS + V_FP;              // 490
  localparam int V_SYNC_LAST  = V_SYNC_FIRST + V_SYNC - 1; // 491

  typedef logic [9:0] hcnt_t;
  typedef logic [9:0] vcnt_t;

endpackage

// File: rtl/vga_sync_counter.sv
// VGA scan position counter.
// Ports:
//   clk, rst    : pixel clock, synchronous active-high reset
//   hcnt        : column 0..799
//   vcnt        : line 0..524, advances when hcnt wraps
//   frame_end   : high in the last cycle of a frame, (799,524)
//   hsync_raw   : undelayed horizontal sync, active low
//   vsync_raw   : undelayed vertical sync, active low
module vga_sync_counter
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] hcnt,
  output logic [9:0] vcnt,
  output logic       frame_end,
  output logic       hsync_raw,
  output logic       vsync_raw
);

  logic line_end;

  assign line_end  = (hcnt == hcnt_t'(H_TOT - 1));
  assign frame_end = line_end && (vcnt == vcnt_t'(V_TOT - 1));

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (line_end) begin
      hcnt <= '0;
      vcnt <= frame_end ? '0 : vcnt + vcnt_t'(1);
    end else begin
      hcnt <= hcnt + hcnt_t'(1);
    end
  end

  assign hsync_raw = !((hcnt >= hcnt_t'(H_SYNC_FIRST)) && (hcnt <= hcnt_t'(H_SYNC_LAST)));
  assign vsync_raw = !((vcnt >= vcnt_t'(V_SYNC_FIRST)) && (vcnt <= vcnt_t'(V_SYNC_LAST)));

endmodule

// File: rtl/vga_frame_reader.sv
// VGA scan-out of a centered grayscale image held in an external memory.
// The block walks the image addresses in raster order, delays sync and the
// image-region flag to line up with the memory's fixed read latency, and
// registers the final sync/RGB so both share one output latency RD_LAT+1.
// Ports:
//   clk, rst     : 25 MHz pixel clock, synchronous active-high reset
//   pixel_data   : memory byte for the address issued RD_LAT cycles earlier
//   pixel_addr   : memory read address, valid with the current scan position
//   hsync, vsync : active-low syncs, registered
//   red/green/blue : gray level inside the image, black elsewhere
//   vga_clk      : inverted pixel clock for the DAC
//   frame_start  : one-cycle pulse when the scan position wraps to (0,0)
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int X0     = 192,
  parameter int Y0     = 112,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pixel_data,
  output logic [15:0] pixel_addr,
  output logic        hsync,
  output logic        vsync,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        vga_clk,
  output logic        frame_start
);

  logic [9:0]  hcnt;
  logic [9:0]  vcnt;
  logic        frame_end;
  logic        hsync_raw;
  logic        vsync_raw;
  logic        in_img;
  logic [15:0] addr_q;

  logic [RD_LAT-1:0] hs_dly;
  logic [RD_LAT-1:0] vs_dly;
  logic [RD_LAT-1:0] img_dly;
  logic [7:0]        gray_q;

  vga_sync_counter u_sync (
    .clk       (clk),
    .rst       (rst),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .frame_end (frame_end),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw)
  );

  assign in_img = (hcnt >= hcnt_t'(X0)) && (hcnt < hcnt_t'(X0 + IMG_W)) &&
                  (vcnt >= vcnt_t'(Y0)) && (vcnt < vcnt_t'(Y0 + IMG_H));

  // Raster-order address: one increment per image pixel, so no multiplier.
  // After the last pixel the counter wraps to 0 and then just holds, since
  // in_img stays low until the next frame.
  always_ff @(posedge clk) begin
    if (rst || frame_end) begin
      addr_q <= '0;
    end else if (in_img) begin
      addr_q <= addr_q + 16'd1;
    end
  end

  assign pixel_addr = addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_end;
    end
  end

  // NOTE: the delay line is reset to the inactive level (not left to power-up
  // contents) so no stale sync pulse or image pixel leaks out after a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_dly  <= '1;
      vs_dly  <= '1;
      img_dly <= '0;
    end else begin
      hs_dly[0]  <= hsync_raw;
      vs_dly[0]  <= vsync_raw;
      img_dly[0] <= in_img;
      for (int i = 1; i < RD_LAT; i++) begin
        hs_dly[i]  <= hs_dly[i-1];
        vs_dly[i]  <= vs_dly[i-1];
        img_dly[i] <= img_dly[i-1];
      end
    end
  end

  // Output stage: the last delay tap is aligned with pixel_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync  <= 1'b1;
      vsync  <= 1'b1;
      gray_q <= '0;
    end else begin
      hsync  <= hs_dly[RD_LAT-1];
      vsync  <= vs_dly[RD_LAT-1];
      gray_q <= img_dly[RD_LAT-1] ? pixel_data : 8'd0;
    end
  end

  assign red   = gray_q;
  assign green = gray_q;
  assign blue  = gray_q;

  // The DAC latches mid-cycle, when the registered outputs are stable.
  assign vga_clk = ~clk;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Self-checking bench for vga_frame_reader: two instances (RD_LAT=1 and 3)
// scanned in parallel against a position-based reference model.
module tb_vga_frame_reader;

  localparam int LINE  = 800;
  localparam int FRAME = 420000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [7:0]  pixel_data1, pixel_data3;
  logic [15:0] pixel_addr1, pixel_addr3;
  logic        hsync1, vsync1, hsync3, vsync3;
  logic [7:0]  red1, green1, blue1, red3, green3, blue3;
  logic        vga_clk1, vga_clk3, fs1, fs3;

  always #20 clk = ~clk;

  vga_frame_reader #(.RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .pixel_data(pixel_data1), .pixel_addr(pixel_addr1),
    .hsync(hsync1), .vsync(vsync1), .red(red1), .green(green1), .blue(blue1),
    .vga_clk(vga_clk1), .frame_start(fs1)
  );

  vga_frame_reader #(.RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .pixel_data(pixel_data3), .pixel_addr(pixel_addr3),
    .hsync(hsync3), .vsync(vsync3), .red(red3), .green(green3), .blue(blue3),
    .vga_clk(vga_clk3), .frame_start(fs3)
  );

  int errors = 0;
  int checks = 0;
  int n      = 0;       // scan cycles since the last reset release
  logic [7:0] tab [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // ---------------- reference model (position arithmetic) ----------------
  function automatic int hpos(input int c); return c % LINE; endfunction
  function automatic int vpos(input int c); return (c / LINE) % 525; endfunction
  function automatic int frame_of(input int c);
    return (c / FRAME > 2) ? 2 : c / FRAME;
  endfunction

  function automatic bit in_image(input int c);
    int h = hpos(c);
    int v = vpos(c);
    return (h >= 192 && h < 448 && v >= 112 && v < 368);
  endfunction

  // Image pixels already scanned in this frame, modulo 2^16.
  function automatic logic [15:0] model_addr(input int c);
    int h = hpos(c);
    int v = vpos(c);
    int rows, cols;
    rows = (v < 112) ? 0 : (v >= 368) ? 256 : v - 112;
    cols = 0;
    if (v >= 112 && v < 368) cols = (h < 192) ? 0 : (h >= 448) ? 256 : h - 192;
    return 16'((rows * 256 + cols) % 65536);
  endfunction

  // Memory contents: frame 0 returns the low address byte, later frames a
  // random table mixed with the high byte.
  function automatic logic [7:0] mem_val(input logic [15:0] a, input int fr);
    if (fr == 0) return a[7:0];
    return tab[a[7:0]] ^ a[15:8];
  endfunction

  // Memory model: outside the image it drives 0xFF to expose leaking border.
  logic [7:0] pipe1 [1];
  logic [7:0] pipe3 [3];
  always @(posedge clk) begin
    pipe1[0] <= in_image(n) ? mem_val(pixel_addr1, frame_of(n)) : 8'hFF;
    pipe3[0] <= in_image(n) ? mem_val(pixel_addr3, frame_of(n)) : 8'hFF;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign pixel_data1 = pipe1[0];
  assign pixel_data3 = pipe3[2];

  task automatic check_dut(input string nm, input int d, input logic [15:0] pa,
                           input logic hs, input logic vs, input logic [7:0] r,
                           input logic [7:0] g, input logic [7:0] b, input logic fs);
    int src = n - d;
    logic e_hs, e_vs;
    logic [7:0] e_px;
    e_hs = 1'b1;
    e_vs = 1'b1;
    e_px = 8'd0;
    if (src >= 0) begin
      e_hs = !(hpos(src) >= 656 && hpos(src) <= 751);
      e_vs = !(vpos(src) >= 490 && vpos(src) <= 491);
      if (in_image(src)) e_px = mem_val(model_addr(src), frame_of(src));
    end
    check({nm, "_addr"}, pa, model_addr(n));
    check({nm, "_hsync"}, hs, e_hs);
    check({nm, "_vsync"}, vs, e_vs);
    check({nm, "_rgb"}, {r, g, b}, {e_px, e_px, e_px});
    check({nm, "_frame_start"}, fs, (n > 0 && n % FRAME == 0));
  endtask

  function automatic int at(input int h, input int v); return v * LINE + h; endfunction

  task automatic named_points();
    if (n == at(192, 112))     check("first_px_addr", pixel_addr1, 0);
    if (n == at(192, 112) + 2) check("first_px_rgb_lat1", red1, 8'h00);
    if (n == at(200, 113))     check("px_200_113_addr", pixel_addr1, 264);
    if (n == at(200, 113) + 2) check("px_200_113_rgb_lat1", red1, 8'h08);
    if (n == at(200, 113) + 3) check("px_200_113_pre_lat3", red3, 8'h07);
    if (n == at(200, 113) + 4) check("px_200_113_rgb_lat3", red3, 8'h08);
    if (n == 2)                check("border_0_0", {red1, green1, blue1}, 0);
    if (n == at(191, 200) + 2) check("border_191_200", {red1, green1, blue1}, 0);
    if (n == at(448, 200) + 2) check("border_448_200", {red1, green1, blue1}, 0);
    if (n == at(300, 480) + 2) check("blank_300_480", {red1, green1, blue1}, 0);
    if (n == at(447, 367))     check("last_px_addr", pixel_addr1, 65535);
    if (n == at(448, 367))     check("addr_wrap", pixel_addr1, 0);
    if (n == FRAME + at(191, 112)) check("addr_hold", pixel_addr1, 0);
    if (n == FRAME + at(193, 112)) check("addr_next_frame", pixel_addr1, 1);
  endtask

  // Independent timing measurements on the sync/frame_start waveforms.
  bit meas_on = 0;
  logic p_hs1 = 1'b1, p_vs1 = 1'b1, p_hs3 = 1'b1, p_vs3 = 1'b1;
  int hs_fall = -1, hs_low = 0, vs_fall = -1, vs_low = 0;
  int hs3_fall = -1, vs3_fall = -1, fs_last = -1, fs_count = 0;

  task automatic measure();
    if (p_hs1 && !hsync1) begin
      if (hs_fall >= 0) check("hs_period", n - hs_fall, 800);
      else check("hs_first_fall_lat1", n, 656 + 2);
      hs_fall = n;
      hs_low  = n;
    end
    if (!p_hs1 && hsync1) check("hs_low_len", n - hs_low, 96);
    if (p_vs1 && !vsync1) begin
      if (vs_fall >= 0) check("vs_period", n - vs_fall, FRAME);
      else check("vs_first_fall_lat1", n, at(0, 490) + 2);
      vs_fall = n;
      vs_low  = n;
    end
    if (!p_vs1 && vsync1) check("vs_low_len", n - vs_low, 1600);
    if (p_hs3 && !hsync3 && hs3_fall < 0) begin
      check("hs_first_fall_lat3", n, 656 + 4);
      hs3_fall = n;
    end
    if (p_vs3 && !vsync3 && vs3_fall < 0) begin
      check("vs_first_fall_lat3", n, at(0, 490) + 4);
      vs3_fall = n;
    end
    if (fs1) begin
      if (fs_last >= 0) check("fs_spacing", n - fs_last, FRAME);
      else check("fs_first", n, FRAME);
      fs_last = n;
      fs_count++;
    end
    p_hs1 = hsync1;
    p_vs1 = vsync1;
    p_hs3 = hsync3;
    p_vs3 = vsync3;
  endtask

  task automatic check_cycle();
    check_dut("lat1", 2, pixel_addr1, hsync1, vsync1, red1, green1, blue1, fs1);
    check_dut("lat3", 4, pixel_addr3, hsync3, vsync3, red3, green3, blue3, fs3);
    named_points();
    if (meas_on) measure();
    if (errors > 40) finish_run();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
    check_cycle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tab[i] = 8'($urandom_range(0, 255));
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n = 0;
    check("vga_clk_high_phase", vga_clk1, 1'b0);
    check("rst_frame_start", fs1, 1'b0);
    check_cycle();
    @(negedge clk);
    #1;
    check("vga_clk_low_phase", vga_clk3, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // First scan: run to (500,300), then a one-cycle mid-frame reset.
    while (n < at(500, 300)) step();
    rst = 1'b1;
    @(posedge clk);
    #1;
    n = 0;
    rst = 1'b0;
    check("midrst_hsync", {hsync1, hsync3}, 2'b11);
    check("midrst_vsync", {vsync1, vsync3}, 2'b11);
    check("midrst_rgb", {red1, green1, blue1, red3}, 32'd0);
    check("midrst_addr", {pixel_addr1, pixel_addr3}, 32'd0);
    check("midrst_no_frame_start", {fs1, fs3}, 2'b00);
    check_cycle();

    // Second scan: two full frames with timing measurements.
    meas_on = 1;
    p_hs1 = hsync1;
    p_vs1 = vsync1;
    p_hs3 = hsync3;
    p_vs3 = vsync3;
    while (n < 2 * FRAME + 10) step();
    check("fs_count", fs_count, 2);
    finish_run();
  end

endmodule

// File: doc/vga_frame_reader.md
# vga_frame_reader

Scan-out stage downstream of the decryption CPU/data adapter: generates 640x480@60 Hz VGA timing from the 25 MHz pixel clock, reads the 256x256 8-bit grayscale decrypted image from image memory, and drives sync plus 24-bit RGB to the board DAC. The image is centered in the visible area; the border and all blanking intervals are black. The block issues `pixel_addr` to the memory and consumes the returned byte on `pixel_data`, compensating for the memory read latency.

## Interface
- `IMG_W`, 256, image width in pixels
- `IMG_H`, 256, image height in lines
- `X0`, 192, first visible column of the image
- `Y0`, 112, first visible line of the image
- `RD_LAT`, 1, image memory read latency in clocks (1..3)

- `clk` in 1: 25 MHz pixel clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `pixel_data` in 8: grayscale byte for the address issued `RD_LAT` cycles earlier.
- `pixel_addr` out 16: image memory read address.
- `hsync` out 1: horizontal sync, active low.
- `vsync` out 1: vertical sync, active low.
- `red`, `green`, `blue` out 8 each: pixel color.
- `vga_clk` out 1: DAC clock, equal to `~clk`; the DAC samples mid-cycle.
- `frame_start` out 1: one-cycle pulse at each frame wrap.

## Operation
- Horizontal counter `hcnt` runs 0..799.
  - Visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Vertical counter `vcnt` runs 0..524 and advances when `hcnt` wraps 799->0.
  - Visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- Region flag `in_img` = (X0 ≤ hcnt < X0+IMG_W) and (Y0 ≤ vcnt < Y0+IMG_H).
- Address counter, no multiplier:
  - cleared to 0 when (hcnt,vcnt) = (799,524) wraps to (0,0);
  - increments by 1 on every cycle with `in_img`=1;
  - holds otherwise.
- `pixel_addr` is driven directly from the address register, so it is valid in the same cycle as the counters that select it.
- Over one frame the address counter walks 0..65535 exactly once. Its increment after the last image pixel wraps to 0 (mod 2^16), and it holds at 0 until the frame clear.
- `hsync_raw` = ~(656 ≤ hcnt ≤ 751); `vsync_raw` = ~(490 ≤ vcnt ≤ 491).
- `hsync_raw`, `vsync_raw` and `in_img` pass through an `RD_LAT`-deep delay line so they align with `pixel_data`.
- Output register stage:
  - `red` = `green` = `blue` = delayed `in_img` ? `pixel_data` : 0;
  - `hsync` and `vsync` are registered from their delayed values.
- `frame_start` = 1 in the cycle where the counters read (0,0) after a wrap. It is not asserted in the first cycle after reset release.
- Reset values:
  - `hcnt`, `vcnt`, address = 0; `pixel_addr` = 0;
  - `hsync` = `vsync` = 1; RGB = 0; `frame_start` = 0;
  - every delay-line stage = inactive (sync 1, `in_img` 0).
- Reset mid-frame: all of the above apply on the next edge. Scan restarts at (0,0), and no partial-frame pixel appears after reset.

## Timing
- Counter state sampled at cycle t appears on `hsync`, `vsync` and RGB at cycle t+RD_LAT+1.
- Fixed output latency D = RD_LAT+1, identical for sync and color, so relative VGA timing is exact.
- Line = 800 clocks; frame = 420000 clocks.
- `hsync` low 96 clocks per line; `vsync` low 1600 clocks per frame.
- First image pixel: counters (192,112) issue address 0; `pixel_data` at t+RD_LAT is output on RGB at t+D.
- Last image pixel: counters (447,367), address 65535.
- No handshake: memory must return data every cycle with fixed latency `RD_LAT`.

## Structure
- Shared package `vga_pkg`:
  - localparams H_VIS/H_FP/H_SYNC/H_BP/H_TOT and V_* equivalents;
  - typedef `hcnt_t`/`vcnt_t` (logic [9:0]).
- Sub-module `vga_sync_counter`: owns `hcnt`/`vcnt`, wrap detection and raw sync flags. It is reused by any later overlay block.
- The address counter, delay line and output stage live in `vga_frame_reader`.

## Test plan
- Reset, release, run 2 frames:
  - `hsync` period 800 with 96 low;
  - `vsync` period 420000 with 1600 low;
  - `frame_start` pulses exactly 420000 apart, first at clock 420000 after release.
- Memory model returning `addr[7:0]`, RD_LAT=1:
  - at counters (192,112) `pixel_addr`=0, and RGB = 0x00 two cycles later;
  - at (200,113) `pixel_addr`=264, and RGB = 0x08 at D.
- Border and blanking pixels (0,0), (191,200), (448,200), (300,480): RGB = 0 even when the memory drives 0xFF.
- After the last image pixel (447,367), `pixel_addr` reads 0 and holds until the next frame's first image pixel.
- Assert `rst` for 1 cycle at (500,300):
  - next cycle hsync=vsync=1, RGB=0, `pixel_addr`=0;
  - counters restart at (0,0) with no `frame_start`.
- RD_LAT=3 build: RGB for counters (192,112) appears exactly 4 cycles later, and the sync edges shift by the same 4 cycles.
